// File: rtl/fir_result_streamer.sv
// Streams a block of FIR result bytes from sample memory to a ready/valid consumer.
// Ports: clk/rst (sync, active-high), start/base_addr/sample_count (job request),
// mem_addr/mem_re/mem_data (read port, 1-cycle latency), out_data/out_valid/
// out_ready/out_last (stream), busy/done (status), checksum/peak (run statistics).
module fir_result_streamer #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] sample_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum,
    output logic [DATA_W-1:0] peak
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;
    logic              r_mem_re;
    logic              r_re_d1;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_rd_left;
    logic [ADDR_W-1:0] r_out_left;
    logic [15:0]       r_checksum;
    logic [DATA_W-1:0] r_peak;

    logic              w_accept;
    logic              w_valid;
    logic              w_fire;
    logic              w_last;
    logic              w_issue;
    logic [PW+1:0]     w_occ;
    logic [DATA_W-1:0] w_head;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_valid  = (r_count != '0);
    assign w_head   = r_fifo[r_rptr];
    assign w_fire   = w_valid && out_ready;
    assign w_last   = (r_out_left == ADDR_W'(1));

    // Occupancy counts buffered samples plus both read-pipeline stages,
    // so every issued read is guaranteed a free FIFO slot on return.
    assign w_occ = (PW+2)'(r_count) + (PW+2)'(r_mem_re) + (PW+2)'(r_re_d1);
    assign w_issue = (r_state == S_STREAM) && (r_rd_left != '0)
                     && (w_occ < (PW+2)'(FIFO_DEPTH));

    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_head : '0;
    assign out_last  = w_valid && w_last;
    assign checksum  = r_checksum;
    assign peak      = r_peak;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (sample_count == '0) ? S_FINISH : S_STREAM;
                end
            end
            S_STREAM: begin
                busy = 1'b1;
                if (w_fire && w_last) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sample storage needs no reset: validity lives in r_count.
    always_ff @(posedge clk) begin
        if (r_re_d1) begin
            r_fifo[r_wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_re   <= 1'b0;
            r_re_d1    <= 1'b0;
            r_mem_addr <= '0;
            r_rd_addr  <= '0;
            r_rd_left  <= '0;
            r_out_left <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_checksum <= '0;
            r_peak     <= '0;
        end else begin
            // r_re_d1 marks the cycle in which mem_data holds a requested byte.
            r_re_d1  <= r_mem_re;
            r_mem_re <= w_issue;
            if (w_issue) begin
                r_mem_addr <= r_rd_addr;
                r_rd_addr  <= r_rd_addr + ADDR_W'(1);
                r_rd_left  <= r_rd_left - ADDR_W'(1);
            end
            if (w_accept) begin
                r_rd_addr  <= base_addr;
                r_rd_left  <= sample_count;
                r_out_left <= sample_count;
                r_checksum <= '0;
                r_peak     <= {1'b1, {(DATA_W-1){1'b0}}};
            end
            if (r_re_d1) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_fire) begin
                r_rptr     <= r_rptr + PW'(1);
                r_out_left <= r_out_left - ADDR_W'(1);
                r_checksum <= r_checksum + 16'(w_head);
                if ($signed(w_head) > $signed(r_peak)) begin
                    r_peak <= w_head;
                end
            end
            case ({r_re_d1, w_fire})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
